// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - req/gnt/rvalid data bus between the load/store unit and memory
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

interface load_store_unit_if #(
    parameter int DATA_WIDTH = `DATA_WIDTH,
    parameter int ADDR_WIDTH = 32
);
    logic                  bus_req_o;
    logic                  bus_we_o;
    logic [ADDR_WIDTH-1:0] bus_addr_o;
    logic [3:0]            bus_be_o;
    logic [DATA_WIDTH-1:0] bus_wdata_o;
    logic                  bus_gnt_i;
    logic                  bus_rvalid_i;
    logic [DATA_WIDTH-1:0] bus_rdata_i;

    modport master (
        output bus_req_o, bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o,
        input  bus_gnt_i, bus_rvalid_i, bus_rdata_i
    );

    modport slave (
        input  bus_req_o, bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o,
        output bus_gnt_i, bus_rvalid_i, bus_rdata_i
    );
endinterface

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - MEM-stage load/store unit: one op at a time on a req/gnt/rvalid bus
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module load_store_unit #(
    parameter int DATA_WIDTH = `DATA_WIDTH,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_valid_i,
    input  logic                  is_store_i,
    input  logic [2:0]            funct3_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic                  stall_o,
    output logic                  done_o,
    output logic                  fault_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    load_store_unit_if.master     bus
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_e;

    state_e                state_q, state_d;
    logic                  is_store_q, is_store_d;
    logic [2:0]            funct3_q, funct3_d;
    logic [1:0]            off_q, off_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [3:0]            be_q, be_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  done_q, done_d;
    logic                  fault_q, fault_d;

    logic                  illegal, misaligned;
    logic [3:0]            be_dec;
    logic [DATA_WIDTH-1:0] wdata_dec;
    logic [DATA_WIDTH-1:0] lane, load_ext;

    // Decode of the incoming op; funct3[1:0] selects the access size for both loads and stores.
    always_comb begin
        illegal    = (funct3_i == 3'b011) || (funct3_i == 3'b110) || (funct3_i == 3'b111)
                   || (is_store_i && funct3_i[2]);
        misaligned = ((funct3_i[1:0] == 2'b01) && addr_i[0])
                   || ((funct3_i[1:0] == 2'b10) && (addr_i[1:0] != 2'b00));
        be_dec     = 4'b1111;
        wdata_dec  = wdata_i;
        case (funct3_i[1:0])
            2'b00: begin
                be_dec    = 4'b0001 << addr_i[1:0];
                wdata_dec = {4{wdata_i[7:0]}};
            end
            2'b01: begin
                be_dec    = addr_i[1] ? 4'b1100 : 4'b0011;
                wdata_dec = {2{wdata_i[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        lane = bus.bus_rdata_i >> {off_q, 3'b000};
        case (funct3_q)
            3'b000:  load_ext = {{(DATA_WIDTH-8){lane[7]}}, lane[7:0]};
            3'b001:  load_ext = {{(DATA_WIDTH-16){lane[15]}}, lane[15:0]};
            3'b100:  load_ext = {{(DATA_WIDTH-8){1'b0}}, lane[7:0]};
            3'b101:  load_ext = {{(DATA_WIDTH-16){1'b0}}, lane[15:0]};
            default: load_ext = lane;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        is_store_d = is_store_q;
        funct3_d   = funct3_q;
        off_d      = off_q;
        we_d       = we_q;
        addr_d     = addr_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        rdata_d    = '0;
        done_d     = 1'b0;
        fault_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    is_store_d = is_store_i;
                    funct3_d   = funct3_i;
                    off_d      = addr_i[1:0];
                    if (illegal || misaligned) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        fault_d = 1'b1;
                    end else begin
                        state_d = S_REQ;
                        we_d    = is_store_i;
                        addr_d  = {addr_i[ADDR_WIDTH-1:2], 2'b00};
                        be_d    = be_dec;
                        wdata_d = wdata_dec;
                    end
                end
            end
            S_REQ: begin
                if (bus.bus_gnt_i) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (bus.bus_rvalid_i) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    rdata_d = is_store_q ? '0 : load_ext;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            is_store_q <= 1'b0;
            funct3_q   <= 3'b000;
            off_q      <= 2'b00;
            we_q       <= 1'b0;
            addr_q     <= '0;
            be_q       <= 4'b0000;
            wdata_q    <= '0;
            rdata_q    <= '0;
            done_q     <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            is_store_q <= is_store_d;
            funct3_q   <= funct3_d;
            off_q      <= off_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            done_q     <= done_d;
            fault_q    <= fault_d;
        end
    end

    // Request comes straight from the state so an async reset drops it at once.
    assign bus.bus_req_o   = (state_q == S_REQ);
    assign bus.bus_we_o    = we_q;
    assign bus.bus_addr_o  = addr_q;
    assign bus.bus_be_o    = be_q;
    assign bus.bus_wdata_o = wdata_q;
    assign stall_o = ((state_q == S_IDLE) && req_valid_i) || (state_q == S_REQ) || (state_q == S_WAIT);
    assign done_o  = done_q;
    assign fault_o = fault_q;
    assign rdata_o = rdata_q;
endmodule
